// File: rtl/mult_sequencer_if.sv
// Client and datapath-control bundle for the shared multiplier sequencer.
// The slave side is the sequencer; the master side is clients plus the datapath.
interface mult_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [1:0]              req_i;
  logic [1:0][WIDTH-1:0]   opS_i;
  logic [1:0][WIDTH-1:0]   opB_i;
  logic                    M_i;
  logic [2*WIDTH-1:0]      AB_i;
  logic [WIDTH-1:0]        S_o;
  logic [WIDTH-1:0]        Bdata_o;
  logic                    LoadB_o;
  logic                    ClearA_o;
  logic                    LoadA_o;
  logic                    Fn_o;
  logic                    Shift_o;
  logic [1:0]              gnt_o;
  logic [1:0]              done_o;
  logic [2*WIDTH-1:0]      result_o;
  logic                    busy_o;

  modport slave (
    input  req_i, opS_i, opB_i, M_i, AB_i,
    output S_o, Bdata_o, LoadB_o, ClearA_o, LoadA_o, Fn_o, Shift_o,
           gnt_o, done_o, result_o, busy_o
  );

  modport master (
    output req_i, opS_i, opB_i, M_i, AB_i,
    input  S_o, Bdata_o, LoadB_o, ClearA_o, LoadA_o, Fn_o, Shift_o,
           gnt_o, done_o, result_o, busy_o
  );
endinterface

// File: rtl/mult_sequencer.sv
// Round-robin two-port arbiter and add-shift sequencer for the shared signed multiplier.
// done_o pulses 2*WIDTH+3 cycles after a request is sampled in IDLE; req_i is ignored while busy.
module mult_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic            Clk,
  input  logic            Reset_n,
  mult_sequencer_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ADD, SHIFT, CAPT, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_nxt;
  logic               sel;
  logic               last_served;
  logic               win;
  logic               loadb;
  logic               cleara;
  logic               fn;
  logic               shift;
  logic               busy;
  logic [1:0]         gnt;
  logic [1:0]         done;
  logic [2*WIDTH-1:0] result;

  // On a tie the port that was not served last wins.
  assign win       = (bus.req_i == 2'b11) ? ~last_served : bus.req_i[1];
  assign count_nxt = count + CW'(1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      count       <= '0;
      sel         <= 1'b0;
      last_served <= 1'b1;
      result      <= '0;
      gnt         <= 2'b00;
      done        <= 2'b00;
      busy        <= 1'b0;
      loadb       <= 1'b0;
      cleara      <= 1'b0;
      fn          <= 1'b0;
      shift       <= 1'b0;
    end else begin
      done   <= 2'b00;
      loadb  <= 1'b0;
      cleara <= 1'b0;
      fn     <= 1'b0;
      shift  <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req_i) begin
            sel    <= win;
            gnt    <= win ? 2'b10 : 2'b01;
            busy   <= 1'b1;
            loadb  <= 1'b1;
            cleara <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          count       <= '0;
          last_served <= sel;
          fn          <= (LAST == '0);
          state       <= ADD;
        end
        ADD: begin
          shift <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          count <= count_nxt;
          if (count == LAST) begin
            state <= CAPT;
          end else begin
            fn    <= (count_nxt == LAST);
            state <= ADD;
          end
        end
        CAPT: begin
          result <= bus.AB_i;
          done   <= sel ? 2'b10 : 2'b01;
          state  <= DONE;
        end
        DONE: begin
          gnt   <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Add-enable follows the live multiplier LSB, so it cannot be registered.
  assign bus.LoadA_o  = (state == ADD) & bus.M_i;
  assign bus.LoadB_o  = loadb;
  assign bus.ClearA_o = cleara;
  assign bus.Fn_o     = fn;
  assign bus.Shift_o  = shift;
  assign bus.gnt_o    = gnt;
  assign bus.done_o   = done;
  assign bus.busy_o   = busy;
  assign bus.result_o = result;
  assign bus.S_o      = (|gnt) ? bus.opS_i[sel] : bus.opS_i[0];
  assign bus.Bdata_o  = (|gnt) ? bus.opB_i[sel] : bus.opB_i[0];
endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: behavioural add-shift datapath, directed stimulus and a done_o scoreboard.
module tb_mult_sequencer;
  localparam int W = 8;

  logic Clk;
  logic Reset_n;
  int   cyc;
  int   total;
  int   bad;

  mult_sequencer_if #(.WIDTH(W)) bus();

  mult_sequencer #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Datapath model: A, B shift registers, X sign bit, 9-bit add/subtract.
  logic [W-1:0] A, B;
  logic         X;
  logic [W:0]   sum_v;

  assign bus.M_i  = B[0];
  assign bus.AB_i = {A, B};

  always @(posedge Clk) begin
    if (bus.ClearA_o) begin
      A <= '0;
      X <= 1'b0;
    end
    if (bus.LoadB_o) B <= bus.Bdata_o;
    if (bus.LoadA_o) begin
      if (bus.Fn_o) sum_v = {A[W-1], A} - {bus.S_o[W-1], bus.S_o};
      else          sum_v = {A[W-1], A} + {bus.S_o[W-1], bus.S_o};
      X <= sum_v[W];
      A <= sum_v[W-1:0];
    end
    if (bus.Shift_o) begin
      A <= {X, A[W-1:1]};
      B <= {A[0], B[W-1:1]};
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0]    port;
    logic [15:0]   res;
    int            at;
    int            loada;
  } exp_t;

  exp_t sbq[$];

  // Monitor: counts control pulses per operation and checks each done_o against the scoreboard.
  int   n_shift, n_fn, n_loada;
  exp_t e;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      n_shift = 0;
      n_fn    = 0;
      n_loada = 0;
    end else begin
      if (bus.LoadB_o) begin
        n_shift = 0;
        n_fn    = 0;
        n_loada = 0;
      end
      if (bus.Shift_o) n_shift++;
      if (bus.Fn_o)    n_fn++;
      if (bus.LoadA_o) n_loada++;
      if (|bus.done_o) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", int'(bus.done_o), 0);
        end else begin
          e = sbq.pop_front();
          check("done_port",   int'(bus.done_o),   int'(e.port));
          check("result",      int'(bus.result_o), int'(e.res));
          check("done_cycle",  cyc,                e.at);
          check("shift_count", n_shift,            W);
          check("fn_count",    n_fn,               1);
          check("loada_count", n_loada,            e.loada);
        end
      end
    end
  end

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!(|bus.done_o) && n < lim);
    check("done_seen", int'(|bus.done_o), 1);
  endtask

  function automatic int ctl();
    return int'({bus.LoadB_o, bus.ClearA_o, bus.LoadA_o, bus.Fn_o, bus.Shift_o});
  endfunction

  int start;
  int stray;

  initial begin
    cyc         = 0;
    total       = 0;
    bad         = 0;
    A           = '0;
    B           = '0;
    X           = 1'b0;
    Reset_n     = 1'b0;
    bus.req_i   = 2'b00;
    bus.opS_i[0] = 8'h11;
    bus.opS_i[1] = 8'h22;
    bus.opB_i[0] = 8'h33;
    bus.opB_i[1] = 8'h44;
    repeat (3) @(negedge Clk);
    check("rst_busy",   int'(bus.busy_o),   0);
    check("rst_gnt",    int'(bus.gnt_o),    0);
    check("rst_done",   int'(bus.done_o),   0);
    check("rst_result", int'(bus.result_o), 0);
    check("rst_ctl",    ctl(),              0);
    check("rst_S",      int'(bus.S_o),      8'h11);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Port 0 alone: 7 x -3 = -21.
    bus.opS_i[0] = 8'd7;
    bus.opB_i[0] = 8'hFD;
    bus.req_i    = 2'b01;
    start = cyc;
    sbq.push_back('{2'b01, 16'hFFEB, start + 19, 7});
    @(negedge Clk);
    check("t1_gnt",   int'(bus.gnt_o),   2'b01);
    check("t1_busy",  int'(bus.busy_o),  1);
    check("t1_ctl",   ctl(),             5'b11000);
    check("t1_Bdata", int'(bus.Bdata_o), 8'hFD);
    wait_done(40);
    bus.req_i = 2'b00;
    repeat (2) @(negedge Clk);
    check("t1_idle_busy", int'(bus.busy_o), 0);

    // Tie straight after reset: port 0 (5 x 6) first, then port 1 (-128 x -128).
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    bus.opS_i[0] = 8'd5;
    bus.opB_i[0] = 8'd6;
    bus.opS_i[1] = 8'h80;
    bus.opB_i[1] = 8'h80;
    bus.req_i    = 2'b11;
    start = cyc;
    sbq.push_back('{2'b01, 16'h001E, start + 19, 2});
    sbq.push_back('{2'b10, 16'h4000, start + 39, 1});
    @(negedge Clk);
    check("t2_gnt_first", int'(bus.gnt_o), 2'b01);
    wait_done(40);
    bus.req_i[0] = 1'b0;
    repeat (2) @(negedge Clk);
    check("t2_gnt_second", int'(bus.gnt_o), 2'b10);
    check("t2_S_port1",    int'(bus.S_o),   8'h80);
    wait_done(40);
    bus.req_i = 2'b00;
    @(negedge Clk);
    check("t2_idle_S_port0", int'(bus.S_o), 8'd5);

    // Port 0 with zero multiplier: -1 x 0.
    bus.opS_i[0] = 8'hFF;
    bus.opB_i[0] = 8'h00;
    bus.req_i    = 2'b01;
    start = cyc;
    sbq.push_back('{2'b01, 16'h0000, start + 19, 0});
    wait_done(40);
    bus.req_i = 2'b00;
    @(negedge Clk);

    // Tie after a port-0 operation: port 1 (3 x 4) wins, then port 0 (-2 x 9).
    bus.opS_i[0] = 8'hFE;
    bus.opB_i[0] = 8'd9;
    bus.opS_i[1] = 8'd3;
    bus.opB_i[1] = 8'd4;
    bus.req_i    = 2'b11;
    start = cyc;
    sbq.push_back('{2'b10, 16'h000C, start + 19, 1});
    sbq.push_back('{2'b01, 16'hFFEE, start + 39, 2});
    @(negedge Clk);
    check("t4_gnt_rr", int'(bus.gnt_o), 2'b10);
    wait_done(40);
    bus.req_i[1] = 1'b0;
    wait_done(40);
    bus.req_i = 2'b00;
    @(negedge Clk);

    // Reset in cycle 8 of an operation: everything drops, no done.
    bus.opS_i[0] = 8'd7;
    bus.opB_i[0] = 8'hFD;
    bus.req_i    = 2'b01;
    repeat (8) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_busy",   int'(bus.busy_o),   0);
    check("mid_rst_gnt",    int'(bus.gnt_o),    0);
    check("mid_rst_ctl",    ctl(),              0);
    check("mid_rst_result", int'(bus.result_o), 0);
    check("mid_rst_done",   int'(bus.done_o),   0);
    bus.req_i = 2'b00;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    bus.opS_i[1] = 8'hFB;
    bus.opB_i[1] = 8'd3;
    bus.req_i    = 2'b10;
    start = cyc;
    sbq.push_back('{2'b10, 16'hFFF1, start + 19, 2});
    wait_done(40);
    bus.req_i = 2'b00;
    @(negedge Clk);

    // Request dropped at cycle 5: 12 x 10 still completes, no new grant afterwards.
    bus.opS_i[0] = 8'd12;
    bus.opB_i[0] = 8'd10;
    bus.req_i    = 2'b01;
    start = cyc;
    sbq.push_back('{2'b01, 16'h0078, start + 19, 2});
    repeat (5) @(negedge Clk);
    bus.req_i = 2'b00;
    wait_done(40);
    stray = 0;
    repeat (6) begin
      @(negedge Clk);
      if (bus.gnt_o != 2'b00 || bus.busy_o) stray++;
    end
    check("t6_no_regrant", stray, 0);

    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Sequencer and two-port arbiter for the shared add-shift signed multiplier datapath (A/B shift registers, 9-bit adder/subtractor, X sign bit). Two client ports request a multiply; the block grants one port round-robin, loads its operands into the datapath, and runs WIDTH add/shift iterations with a subtract on the final iteration. It captures the 2·WIDTH-bit product and returns it with a done pulse to the granted port. It sits between the client logic and the multiplier datapath and is the only driver of the datapath control lines.

## Interface
- WIDTH, 8, operand width in bits; product width is 2·WIDTH; iteration counter is $clog2(WIDTH+1) bits
- Clk  in  1  system clock, all state changes on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- req_i  in  2  per-port request; held high by the client until its done_o bit pulses
- opS_i  in  2×WIDTH  per-port multiplicand (two's complement), driven to the S bus
- opB_i  in  2×WIDTH  per-port multiplier (two's complement), loaded into register B
- M_i  in  1  current LSB of register B, from datapath
- AB_i  in  2·WIDTH  {A,B} register contents, from datapath
- S_o  out  WIDTH  multiplicand to the datapath adder, muxed from the granted port
- Bdata_o  out  WIDTH  multiplier load value, muxed from the granted port
- LoadB_o, ClearA_o, LoadA_o, Fn_o, Shift_o  out  1 each  datapath controls (Fn_o=1 selects subtract)
- gnt_o  out  2  one-hot grant, high from LOAD through DONE
- done_o  out  2  one-cycle pulse on the granted port's bit in DONE
- result_o  out  2·WIDTH  captured product, held until the next capture
- busy_o  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, ADD, SHIFT, CAPT, DONE.
- IDLE: if any req_i bit is high, latch the winner in sel and go to LOAD; otherwise stay.
- Arbitration: one request wins outright. With both requests high, the port other than last_served wins. last_served resets to 1, so port 0 wins the first tie.
- LOAD: LoadB_o=1 and ClearA_o=1 (clears A and X). Clear count=0. Set last_served=sel. Next state is ADD.
- ADD: LoadA_o=M_i (combinational). Fn_o=1 only when count==WIDTH-1. Next state is SHIFT.
- SHIFT: Shift_o=1. Increment count. If count==WIDTH-1 before the increment, go to CAPT; otherwise go to ADD.
- CAPT: result_o <= AB_i on the exit edge. All datapath controls are 0. Next state is DONE.
- DONE: done_o[sel]=1. Next state is IDLE.
- In IDLE, CAPT and DONE, all datapath control outputs are 0.
- S_o and Bdata_o: port sel's operands while gnt_o≠0; port 0's operands in IDLE.
- Operands must be stable from LOAD through the last ADD. They are not registered internally.
- req_i is ignored outside IDLE. A request dropped mid-operation does not abort; done_o still pulses.
- If a client keeps req_i high in the cycle after DONE, it is re-arbitrated as a new request.
- Arithmetic: the product is the datapath's signed 2·WIDTH result, passed through unmodified. -2^(WIDTH-1) × -2^(WIDTH-1) = +2^(2·WIDTH-2) is representable.

## Timing
- Reset (async assert, synchronous release):
  - state=IDLE, count=0, sel=0, last_served=1.
  - result_o=0, gnt_o=0, done_o=0, busy_o=0.
  - All datapath controls are 0 during reset.
- Reset asserted mid-operation: all outputs drop immediately. No done_o pulse. The datapath contents are don't-care.
- Latency: req_i sampled high in IDLE at cycle 0. LOAD at 1, ADD/SHIFT at 2…2·WIDTH+1, CAPT at 2·WIDTH+2, DONE at 2·WIDTH+3.
- For WIDTH=8, done_o pulses at cycle 19.
- result_o is valid in the DONE cycle and stays stable until the next CAPT exit.
- Back-to-back throughput: one product per 2·WIDTH+4 cycles (DONE returns to IDLE, then IDLE re-arbitrates).
- Fn_o is asserted in exactly one ADD per operation, the WIDTH-th one. Shift_o is asserted exactly WIDTH times.

## Test plan
- Port 0 only, opS=7, opB=-3 (8'hFD) → gnt_o=01 at cycle 1, done_o=01 at cycle 19, result_o=16'hFFEB (-21).
- Both requests in the same cycle after reset: port 0 has 5×6, port 1 has -128×-128 → port 0 first (result 16'h001E, done_o=01 at 19). Port 1 is then granted at 21 with result 16'h4000 (done_o=10 at 39).
- Round-robin: after a port-0 operation completes, both request together → port 1 is granted first.
- Multiplier 0 (opB=0), opS=-1 → LoadA_o is never asserted, Shift_o is counted 8 times, result_o=16'h0000.
- Reset_n pulled low at cycle 8 of an operation → busy_o, gnt_o and all controls are 0 immediately, result_o=0, no done_o. After release a new request completes normally in 19 cycles.
- req_i dropped at cycle 5 of an operation → the operation completes, done_o pulses at cycle 19, and the block returns to IDLE with no new grant.
